// File: rtl/spi_master_mc.sv
// Multi-slave SPI master: runtime CPOL/CPHA per transfer, programmable SCLK divider,
// selectable bit order and one-hot active-low slave selects. All outputs registered.
module spi_master_mc #(
  parameter int DATA_W    = 8,
  parameter int NUM_SS    = 4,
  parameter int CLK_DIV   = 4,
  parameter int MSB_FIRST = 1,
  localparam int SS_W     = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_transfer,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic              cpol,
  input  logic              cpha,
  output logic              busy,
  output logic              transfer_done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic [NUM_SS-1:0] ss_n,
  output logic              mosi,
  input  logic              miso
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W);
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST  = EDGE_W'(2 * DATA_W - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST2 = EDGE_W'(2 * DATA_W - 2);

  logic [1:0]        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              sclk_q, sclk_d;
  logic [NUM_SS-1:0] ss_n_q, ss_n_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              div_end;
  logic              ss_valid;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
  endfunction

  assign div_end  = (div_q == DIV_LAST);
  assign ss_valid = int'(ss_sel) < NUM_SS;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q + 1'b1;
    edge_d    = edge_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    sclk_d    = sclk_q;
    ss_n_d    = ss_n_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        sclk_d = cpol;
        busy_d = 1'b0;
        div_d  = '0;
        // busy_q is still high in the done cycle, which blocks an accept there
        if (start_transfer && ss_valid && !busy_q) begin
          state_d = S_SETUP;
          cpol_d  = cpol;
          cpha_d  = cpha;
          busy_d  = 1'b1;
          rx_sh_d = '0;
          ss_n_d  = ~(NUM_SS'(1) << ss_sel);
          if (cpha) begin
            mosi_d = 1'b0;
            tx_d   = tx_data;
          end else begin
            mosi_d = first_bit(tx_data);
            tx_d   = shift_out(tx_data);
          end
        end
      end
      S_SETUP: begin
        if (div_end) begin
          state_d = S_XFER;
          div_d   = '0;
          edge_d  = '0;
          sclk_d  = ~cpol_q;
          if (cpha_q) begin
            mosi_d = first_bit(tx_q);
            tx_d   = shift_out(tx_q);
          end
        end
      end
      S_XFER: begin
        // edge_q even = leading edge shown this cycle, odd = trailing
        if (div_q == '0 && (edge_q[0] == cpha_q)) rx_sh_d = shift_in(rx_sh_q, miso);
        if (div_end) begin
          div_d = '0;
          if (edge_q == EDGE_LAST) begin
            state_d = S_HOLD;
            sclk_d  = cpol_q;
          end else begin
            edge_d = edge_q + 1'b1;
            sclk_d = ~sclk_q;
            if (edge_q[0] ? cpha_q : (!cpha_q && edge_q != EDGE_LAST2)) begin
              mosi_d = first_bit(tx_q);
              tx_d   = shift_out(tx_q);
            end
          end
        end
      end
      default: begin
        if (div_end) begin
          state_d   = S_IDLE;
          ss_n_d    = '1;
          mosi_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      edge_q    <= '0;
      tx_q      <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      sclk_q    <= 1'b0;
      ss_n_q    <= '1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      edge_q    <= edge_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      sclk_q    <= sclk_d;
      ss_n_q    <= ss_n_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy          = busy_q;
  assign transfer_done = done_q;
  assign rx_data       = rx_data_q;
  assign sclk          = sclk_q;
  assign ss_n          = ss_n_q;
  assign mosi          = mosi_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Bench for spi_master_mc: three instances (8-bit/div2, 16-bit LSB-first, 8-bit/div1),
// a mode-aware slave model on instance A and per-instance rx scoreboards.
module tb_spi_master_mc;

  localparam int CDA = 2;
  localparam int CDB = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Instance A: 8-bit, 4 selects, divider 2, MSB first
  logic       start_a, cpol_a, cpha_a, busy_a, done_a, sclk_a, mosi_a, miso_a;
  logic [7:0] tx_a, rx_a;
  logic [1:0] sel_a;
  logic [3:0] ssn_a;
  bit         loop_a;

  // Instance B: 16-bit, 3 selects, divider 2, LSB first
  logic        start_b, cpol_b, cpha_b, busy_b, done_b, sclk_b, mosi_b;
  logic [15:0] tx_b, rx_b;
  logic [1:0]  sel_b;
  logic [2:0]  ssn_b;

  // Instance C: 8-bit, 1 select, divider 1, MSB first
  logic       start_c, cpol_c, cpha_c, busy_c, done_c, sclk_c, mosi_c;
  logic [7:0] tx_c, rx_c;
  logic [0:0] sel_c, ssn_c;

  spi_master_mc #(.DATA_W(8), .NUM_SS(4), .CLK_DIV(CDA), .MSB_FIRST(1)) u_a (
    .clk(clk), .rst(rst), .start_transfer(start_a), .tx_data(tx_a), .ss_sel(sel_a),
    .cpol(cpol_a), .cpha(cpha_a), .busy(busy_a), .transfer_done(done_a), .rx_data(rx_a),
    .sclk(sclk_a), .ss_n(ssn_a), .mosi(mosi_a), .miso(miso_a));

  spi_master_mc #(.DATA_W(16), .NUM_SS(3), .CLK_DIV(CDB), .MSB_FIRST(0)) u_b (
    .clk(clk), .rst(rst), .start_transfer(start_b), .tx_data(tx_b), .ss_sel(sel_b),
    .cpol(cpol_b), .cpha(cpha_b), .busy(busy_b), .transfer_done(done_b), .rx_data(rx_b),
    .sclk(sclk_b), .ss_n(ssn_b), .mosi(mosi_b), .miso(mosi_b));

  spi_master_mc #(.DATA_W(8), .NUM_SS(1), .CLK_DIV(1), .MSB_FIRST(1)) u_c (
    .clk(clk), .rst(rst), .start_transfer(start_c), .tx_data(tx_c), .ss_sel(sel_c),
    .cpol(cpol_c), .cpha(cpha_c), .busy(busy_c), .transfer_done(done_c), .rx_data(rx_c),
    .sclk(sclk_c), .ss_n(ssn_c), .mosi(mosi_c), .miso(mosi_c));

  // SPI slave model for A: drives miso / samples mosi according to its own CPHA setting
  bit       slv_act, slv_lead, slv_prev, slv_miso, slv_cpha;
  bit [1:0] slv_idx;
  bit [7:0] slv_resp, slv_tx, slv_rcv;

  assign miso_a = loop_a ? mosi_a : slv_miso;

  always @(negedge clk) begin
    if (ssn_a[slv_idx]) begin
      slv_act <= 1'b0;
    end else if (!slv_act) begin
      slv_act  <= 1'b1;
      slv_lead <= 1'b1;
      slv_prev <= sclk_a;
      slv_rcv  <= '0;
      if (!slv_cpha) begin
        slv_miso <= slv_resp[7];
        slv_tx   <= {slv_resp[6:0], 1'b0};
      end else begin
        slv_tx <= slv_resp;
      end
    end else if (sclk_a != slv_prev) begin
      slv_prev <= sclk_a;
      slv_lead <= ~slv_lead;
      if (slv_lead == slv_cpha) begin
        slv_miso <= slv_tx[7];
        slv_tx   <= {slv_tx[6:0], 1'b0};
      end else begin
        slv_rcv <= {slv_rcv[6:0], mosi_a};
      end
    end
  end

  // Scoreboards: expected rx pushed on request, popped on transfer_done
  logic [31:0] q_a[$], q_b[$], q_c[$];

  always @(negedge clk) begin
    if (done_a) begin
      if (q_a.size() == 0) check("done_a_unexpected", 1, 0);
      else check("rx_a", {24'h0, rx_a}, q_a.pop_front());
    end
    if (done_b) begin
      if (q_b.size() == 0) check("done_b_unexpected", 1, 0);
      else check("rx_b", {16'h0, rx_b}, q_b.pop_front());
    end
    if (done_c) begin
      if (q_c.size() == 0) check("done_c_unexpected", 1, 0);
      else check("rx_c", {24'h0, rx_c}, q_c.pop_front());
    end
  end

  typedef struct {
    logic       pol;
    logic       pha;
    logic [1:0] sel;
    logic [7:0] tx;
    bit         loop;
    logic [7:0] resp;
    logic [3:0] ssn;
    bit         poke;
  } vec_t;

  vec_t vecs[7];

  task automatic run_a(input vec_t v);
    int   done_n = 0, low_n = 0, rise_n = 0, mosi_n = 0;
    logic prev_s = v.pol;
    bit   ss3_low = 1'b0;
    tx_a = v.tx; sel_a = v.sel; cpol_a = v.pol; cpha_a = v.pha; loop_a = v.loop;
    slv_resp = v.resp; slv_cpha = v.pha; slv_idx = v.sel;
    start_a = 1'b1;
    q_a.push_back(v.loop ? {24'h0, v.tx} : {24'h0, v.resp});
    for (int n = 1; n <= 200 && done_n == 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start_a = 1'b0;
        check("ss_sel_a", ssn_a, v.ssn);
        check("sclk_setup_a", sclk_a, v.pol);
        check("busy_a", busy_a, 1);
      end
      if (v.poke && n == 10) begin
        start_a = 1'b1; sel_a = 2'd3; tx_a = ~v.tx; cpol_a = ~v.pol; cpha_a = ~v.pha;
      end
      if (v.poke && n == 11) start_a = 1'b0;
      if (ssn_a != 4'hF) low_n++;
      if (!ssn_a[3] && v.sel != 2'd3) ss3_low = 1'b1;
      if (sclk_a && !prev_s) rise_n++;
      prev_s = sclk_a;
      if (mosi_a && mosi_n == 0) mosi_n = n;
      if (done_a) done_n = n;
    end
    check("done_time_a", done_n, 1 + (2 * 8 + 2) * CDA);
    check("ss_low_a", low_n, (2 * 8 + 2) * CDA);
    check("sclk_rises_a", rise_n, 8);
    if (v.tx[7]) check("mosi_first_a", mosi_n, v.pha ? 1 + CDA : 1);
    if (!v.loop) check("slave_rcv_a", slv_rcv, v.tx);
    if (v.poke) check("ss3_never_low_a", ss3_low, 0);
    @(negedge clk);
    check("busy_drop_a", busy_a, 0);
    if (!v.poke) check("sclk_idle_a", sclk_a, v.pol);
  endtask

  initial begin
    int   done_n, cnt, tog, first_t, last_t, rises;
    logic prev;
    logic [15:0] cap;

    vecs[0] = '{1'b0, 1'b0, 2'd0, 8'h5A, 1'b1, 8'h00, 4'hE, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 2'd1, 8'hC3, 1'b0, 8'hAA, 4'hD, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 2'd2, 8'hC3, 1'b0, 8'hAA, 4'hB, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 2'd3, 8'hC3, 1'b0, 8'hAA, 4'h7, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 2'd0, 8'hC3, 1'b0, 8'hAA, 4'hE, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 2'd0, 8'hA5, 1'b1, 8'h00, 4'hE, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 2'd2, 8'h96, 1'b1, 8'h00, 4'hB, 1'b0};

    rst = 1'b1;
    start_a = 0; tx_a = 0; sel_a = 0; cpol_a = 0; cpha_a = 0; loop_a = 1'b1;
    start_b = 0; tx_b = 0; sel_b = 0; cpol_b = 0; cpha_b = 0;
    start_c = 0; tx_c = 0; sel_c = 0; cpol_c = 0; cpha_c = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sclk", sclk_a, 0);
    check("rst_ssn", ssn_a, 4'hF);
    check("rst_mosi", mosi_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_rx", rx_a, 0);
    check("rst_ssn_b", ssn_b, 3'h7);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) run_a(vecs[i]);

    // Reset during the 5th bit of a transfer
    tx_a = 8'h77; sel_a = 2'd1; cpol_a = 1'b1; cpha_a = 1'b0; loop_a = 1'b1; start_a = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) start_a = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_sclk", sclk_a, 0);
    check("abort_ssn", ssn_a, 4'hF);
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    check("abort_rx", rx_a, 0);
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done_a || busy_a) cnt++;
    end
    check("abort_quiet", cnt, 0);
    run_a('{1'b0, 1'b0, 2'd0, 8'h3C, 1'b1, 8'h00, 4'hE, 1'b0});

    // Invalid slave index on B (NUM_SS=3)
    sel_b = 2'd3; tx_b = 16'hBEEF; start_b = 1'b1;
    cnt = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (busy_b || done_b || ssn_b != 3'h7) cnt++;
    end
    check("invalid_sel_b", cnt, 0);

    // LSB-first 16-bit loopback on B
    tx_b = 16'h1234; sel_b = 2'd2; cpol_b = 1'b0; cpha_b = 1'b0; start_b = 1'b1;
    q_b.push_back(32'h1234);
    cap = '0; rises = 0; prev = 1'b0; done_n = 0;
    for (int n = 1; n <= 400 && done_n == 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start_b = 1'b0;
        check("ss_sel_b", ssn_b, 3'b011);
      end
      if (sclk_b && !prev) begin
        cap = {mosi_b, cap[15:1]};
        rises++;
      end
      prev = sclk_b;
      if (done_b) done_n = n;
    end
    check("mosi_order_b", cap, 16'h1234);
    check("sclk_rises_b", rises, 16);
    check("done_time_b", done_n, 1 + (2 * 16 + 2) * CDB);

    // Divider 1 on C
    tx_c = 8'hFF; sel_c = 1'b0; start_c = 1'b1;
    q_c.push_back(32'hFF);
    tog = 0; first_t = 0; last_t = 0; prev = 1'b0; done_n = 0;
    for (int n = 1; n <= 100 && done_n == 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start_c = 1'b0;
        check("ss_sel_c", ssn_c, 1'b0);
      end
      if (sclk_c != prev) begin
        tog++;
        if (first_t == 0) first_t = n;
        last_t = n;
      end
      prev = sclk_c;
      if (done_c) done_n = n;
    end
    check("toggles_c", tog, 16);
    check("first_toggle_c", first_t, 2);
    check("last_toggle_c", last_t, 17);
    check("done_time_c", done_n, 19);

    repeat (3) @(negedge clk);
    check("sb_empty", q_a.size() + q_b.size() + q_c.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
